rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum consecutive grant cycles per owner (legal range 2..256).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port en, input, 1, arbitration enable; low means no new grants and release of the current grant.
REQ-005 The block SHALL have port req, input, 4, per-requester request, bit i is requester i.
REQ-006 The block SHALL have port done, input, 1, the current owner's release strobe.
REQ-007 The block SHALL have port grant, output, 4, registered one-hot grant; all-zero when no owner.
REQ-008 The block SHALL have port gnt_id, output, 2, registered binary index of the owner; 0 when no owner.
REQ-009 The block SHALL have port gnt_valid, output, 1, registered, high exactly when grant is non-zero.
REQ-010 The block SHALL have port timeout, output, 1, registered one-cycle pulse on a forced release at the hold limit.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (one owner).
REQ-012 In IDLE with en=1 and req!=0, the block SHALL select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), and enter OWN.
REQ-013 Grant latency SHALL be one cycle: req sampled at edge N gives grant/gnt_id/gnt_valid valid after edge N.
REQ-014 The block SHALL keep grant always equal to the one-hot decode of gnt_id when gnt_valid=1, and 4'b0000 otherwise.
REQ-015 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with outputs unchanged at zero.
REQ-016 In OWN, the block SHALL release at the next edge if done=1, or req[gnt_id]=0, or en=0, or hold_cnt=MAX_HOLD-1.
REQ-017 The hold counter SHALL load 0 on entry to OWN, increment by 1 each OWN cycle without release, and never wrap.
REQ-018 An owner SHALL therefore hold grant for at most MAX_HOLD consecutive cycles.
REQ-019 On release, the block SHALL go to IDLE, clear grant/gnt_id/gnt_valid, and set ptr to gnt_id+1 mod 4 (3 wraps to 0).
REQ-020 After every release, the block SHALL show at least one IDLE cycle with grant=0, with no back-to-back grants.
REQ-021 The block SHALL set timeout=1 for one cycle only when the release cause is the hold limit and done=0, req[gnt_id]=1, en=1.
REQ-022 When several release causes coincide, the release SHALL occur once and timeout SHALL stay 0 unless REQ-021 holds.
REQ-023 The block SHALL ignore requests from non-owners while in OWN; they are arbitrated at the next IDLE cycle.
REQ-024 The block SHALL ignore done while in IDLE.

Reset
REQ-025 While rst=1, the block SHALL immediately (asynchronously) force state=IDLE, ptr=0, hold_cnt=0, grant=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0.
REQ-026 Reset asserted mid-grant SHALL abort the grant with no timeout pulse.
REQ-027 After reset release, the first arbitration SHALL start from ptr=0, so requester 0 has priority.

Verification
REQ-028 The bench SHALL cover rst pulse, then req=4'b1111, en=1 -> grant 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000 (each owner releases with done after 1 cycle), then 0001 again (wrap).
REQ-029 The bench SHALL cover req=4'b0100 held, done=0, MAX_HOLD=16 -> grant=0100 for exactly 16 cycles; timeout=1 on the cycle grant returns to 0000; then regrant 0100 after 1 idle cycle.
REQ-030 The bench SHALL cover requester 1 owning while req=4'b1011, then done=1 -> next grant 1000 (ptr=2 skips absent 2), not 0001.
REQ-031 The bench SHALL cover en=0 during ownership of requester 3 -> grant=0000 after the next edge, timeout=0, no regrant while en=0; en=1 -> grant 0001 (ptr wrapped to 0).
REQ-032 The bench SHALL cover rst asserted between edges during grant 0010 -> grant=0000 and gnt_valid=0 without waiting for clk; after release with req=4'b0010 -> grant 0010 one cycle later.
REQ-033 The bench SHALL cover done=1 together with hold_cnt=MAX_HOLD-1 -> single release, timeout=0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with one-cycle grant latency, a bounded hold
// time per owner and a mandatory idle cycle between consecutive owners.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, id_nxt, cand;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          to_nxt, found, rel, at_lim;

  assign at_lim = (cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = gnt_id;
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
    found     = 1'b0;
    cand      = ptr;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        id_nxt = 2'd0;
        // Rotating scan starting at ptr; first hit wins.
        if (en) begin
          for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
              found  = 1'b1;
              id_nxt = cand;
            end
          end
        end
        if (found) begin
          state_nxt = OWN;
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        rel = done | ~req[gnt_id] | ~en | at_lim;
        if (rel) begin
          state_nxt = IDLE;
          id_nxt    = 2'd0;
          ptr_nxt   = gnt_id + 2'd1;
          cnt_nxt   = '0;
          // Timeout only when the hold limit is the sole reason to let go.
          to_nxt    = at_lim & ~done & req[gnt_id] & en;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      grant     <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= (state_nxt == OWN);
      grant     <= (state_nxt == OWN) ? (4'b0001 << id_nxt) : 4'b0000;
      timeout   <= to_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a rotation table plus hand-written
// sequences for hold-limit, enable, skip and asynchronous reset cases.
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk = 0;
  int n_pass = 0;

  rr_arbiter4 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .grant(grant), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t tbl[9];

  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] id,
                     input logic v, input logic t);
    n_chk++;
    if ({grant, gnt_id, gnt_valid, timeout} === {g, id, v, t}) n_pass++;
    else $display("FAIL %s: got grant=%b id=%0d valid=%b to=%b, want grant=%b id=%0d valid=%b to=%b",
                  nm, grant, gnt_id, gnt_valid, timeout, g, id, v, t);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[2] = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[3] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[4] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[5] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[6] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[7] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[8] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};

    #2;
    chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Rotation with single-cycle ownership, wrapping back to 0.
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      tick();
      chk($sformatf("rotate_%0d", i), tbl[i].grant, tbl[i].id,
          tbl[i].grant != 4'b0000, tbl[i].to);
    end
    tick();  // owner 0 releases, ptr -> 1
    chk("rotate_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Requester 1 owns with req=1011; after done, ptr=2 skips absent 2.
    req = 4'b1011; done = 1'b0;
    tick(); chk("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("own1_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("own1_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick(); chk("skip_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Enable dropped while 3 owns.
    en = 1'b0;
    tick(); chk("en_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("en_low_idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("en_low_idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk("en_back_wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Hold limit: requester 2 alone for exactly 16 cycles then timeout.
    req = 4'b0100;
    tick(); chk("owner0_req_gone", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("hold_c0", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick(); chk($sformatf("hold_c%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick(); chk("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); chk("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done coincides with the last hold cycle: single release, no timeout.
    for (int i = 1; i < 16; i++) tick();
    chk("lim_last_cycle", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("lim_with_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick(); chk("lim_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Asynchronous reset between edges during grant 0010.
    req = 4'b0010;
    tick(); chk("pre_rst_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("pre_rst_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    rst = 1'b1;
    #1; chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1; rst = 1'b0;
    tick(); chk("post_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // ptr restarts at 0 after reset: requester 0 wins among all.
    rst = 1'b1; req = 4'b1111;
    #2; rst = 1'b0;
    tick(); chk("post_rst_prio0", 4'b0001, 2'd0, 1'b1, 1'b0);
    // done ignored in IDLE: owner releases, next IDLE cycle ignores done.
    done = 1'b1;
    tick(); chk("done_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("done_idle_ignored", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
